// File: rtl/kf8237_address_count_array.sv
// Per-channel base/current address, word count and page registers for the KF8237 DMA core,
// with byte-serial CPU access, transfer stepping, auto-initialize reload and sticky TC flags.
module kf8237_address_count_array #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 16,
    parameter int PAGE_WIDTH = 8,
    localparam int CH_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int PW        = (PAGE_WIDTH > 0) ? PAGE_WIDTH : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          internal_data_bus,
    output logic [7:0]          read_data,
    input  logic [CHANNELS-1:0] write_address,
    input  logic [CHANNELS-1:0] write_count,
    input  logic [CHANNELS-1:0] write_page,
    input  logic [CHANNELS-1:0] read_address,
    input  logic [CHANNELS-1:0] read_count,
    input  logic                read_done,
    input  logic                clear_byte_pointer,
    input  logic                master_clear,
    input  logic [CH_BITS-1:0]  channel_select,
    input  logic                initialize,
    input  logic                next_word,
    input  logic                address_hold,
    input  logic                address_decrement,
    input  logic [CHANNELS-1:0] autoinit_enable,
    input  logic                page_carry_enable,
    input  logic                clear_tc_status,
    output logic [WIDTH-1:0]    transfer_address,
    output logic [PW-1:0]       transfer_page,
    output logic                update_high_address,
    output logic                terminal_count,
    output logic [CHANNELS-1:0] tc_status
);

    localparam int BYTES    = WIDTH / 8;
    localparam int PTR_BITS = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [PTR_BITS-1:0] PTR_LAST  = PTR_BITS'(BYTES - 1);
    localparam logic [PTR_BITS-1:0] PTR_ONE   = PTR_BITS'(1);
    localparam logic [WIDTH-1:0]    ONE       = WIDTH'(1);
    localparam logic [PW-1:0]       PAGE_ONE  = PW'(1);
    localparam logic [WIDTH-1:0]    HIGH_MASK = ~WIDTH'(8'hFF);

    logic [WIDTH-1:0]    base_addr [CHANNELS];
    logic [WIDTH-1:0]    cur_addr  [CHANNELS];
    logic [WIDTH-1:0]    base_cnt  [CHANNELS];
    logic [WIDTH-1:0]    cur_cnt   [CHANNELS];
    logic [PW-1:0]       base_page [CHANNELS];
    logic [PW-1:0]       cur_page  [CHANNELS];
    logic [PTR_BITS-1:0] byte_ptr;

    logic [CH_BITS-1:0]  sel;
    logic [WIDTH-1:0]    addr_now, addr_step, addr_next, cnt_now, cnt_next;
    logic [PW-1:0]       page_now, page_step, page_next;
    logic                underflow, cpu_hit, step, wrap, reload, found;

    function automatic logic [7:0] get_byte(input logic [WIDTH-1:0] v,
                                            input logic [PTR_BITS-1:0] p);
        logic [7:0] r;
        r = 8'h00;
        for (int b = 0; b < BYTES; b++)
            if (p == PTR_BITS'(b)) r = v[8*b +: 8];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] set_byte(input logic [WIDTH-1:0] v,
                                                  input logic [PTR_BITS-1:0] p,
                                                  input logic [7:0] d);
        logic [WIDTH-1:0] r;
        r = v;
        for (int b = 0; b < BYTES; b++)
            if (p == PTR_BITS'(b)) r[8*b +: 8] = d;
        return r;
    endfunction

    // Out-of-range channel numbers alias onto channel 0.
    always_comb begin
        sel = '0;
        if (int'(channel_select) < CHANNELS) sel = channel_select;
    end

    always_comb begin
        addr_now  = cur_addr[sel];
        cnt_now   = cur_cnt[sel];
        page_now  = cur_page[sel];
        underflow = (cnt_now == '0);
        cpu_hit   = write_address[sel] | write_count[sel] | write_page[sel];
        step      = next_word && !initialize && !cpu_hit;

        addr_step = addr_now;
        if (!address_hold) addr_step = address_decrement ? addr_now - ONE : addr_now + ONE;
        wrap = !address_hold && (address_decrement ? (addr_now == '0) : (&addr_now));

        page_step = page_now;
        if (PAGE_WIDTH > 0 && page_carry_enable && wrap)
            page_step = address_decrement ? page_now - PAGE_ONE : page_now + PAGE_ONE;

        // Auto-initialize replaces the step entirely on underflow.
        reload    = underflow && autoinit_enable[sel];
        addr_next = reload ? base_addr[sel] : addr_step;
        cnt_next  = reload ? base_cnt[sel]  : cnt_now - ONE;
        page_next = reload ? base_page[sel] : page_step;

        update_high_address = step && ((((addr_next ^ addr_now) & HIGH_MASK) != '0) ||
                                       (page_next != page_now));
    end

    // Address selects outrank count selects, lower channel first.
    always_comb begin
        read_data = 8'h00;
        found     = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (!found && read_address[c]) begin
                read_data = get_byte(cur_addr[c], byte_ptr);
                found     = 1'b1;
            end
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (!found && read_count[c]) begin
                read_data = get_byte(cur_cnt[c], byte_ptr);
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || master_clear) begin
            for (int c = 0; c < CHANNELS; c++) begin
                base_addr[c] <= '0;
                cur_addr[c]  <= '0;
                base_cnt[c]  <= '0;
                cur_cnt[c]   <= '0;
                base_page[c] <= '0;
                cur_page[c]  <= '0;
            end
            byte_ptr         <= '0;
            tc_status        <= '0;
            transfer_address <= '0;
            transfer_page    <= '0;
            terminal_count   <= 1'b0;
        end else begin
            if (clear_byte_pointer)
                byte_ptr <= '0;
            else if ((|write_address) || (|write_count) || read_done)
                byte_ptr <= (byte_ptr == PTR_LAST) ? '0 : byte_ptr + PTR_ONE;

            terminal_count   <= step && underflow;
            transfer_address <= cur_addr[sel];
            transfer_page    <= cur_page[sel];

            for (int c = 0; c < CHANNELS; c++) begin
                if (write_address[c] || write_count[c] || write_page[c]) begin
                    if (write_address[c]) begin
                        base_addr[c] <= set_byte(base_addr[c], byte_ptr, internal_data_bus);
                        cur_addr[c]  <= set_byte(cur_addr[c], byte_ptr, internal_data_bus);
                    end
                    if (write_count[c]) begin
                        base_cnt[c] <= set_byte(base_cnt[c], byte_ptr, internal_data_bus);
                        cur_cnt[c]  <= set_byte(cur_cnt[c], byte_ptr, internal_data_bus);
                    end
                    if (write_page[c] && PAGE_WIDTH > 0) begin
                        base_page[c] <= internal_data_bus[PW-1:0];
                        cur_page[c]  <= internal_data_bus[PW-1:0];
                    end
                end else if (sel == CH_BITS'(c)) begin
                    if (initialize) begin
                        cur_addr[c] <= base_addr[c];
                        cur_cnt[c]  <= base_cnt[c];
                        cur_page[c] <= base_page[c];
                    end else if (step) begin
                        cur_addr[c] <= addr_next;
                        cur_cnt[c]  <= cnt_next;
                        cur_page[c] <= page_next;
                    end
                end

                // A terminal count arriving with a status clear keeps its flag.
                if (step && underflow && sel == CH_BITS'(c))
                    tc_status[c] <= 1'b1;
                else if (clear_tc_status)
                    tc_status[c] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kf8237_address_count_array.sv
// Directed bench for kf8237_address_count_array with hand-computed expectations.
module tb_kf8237_address_count_array;

    localparam int WA = 0;
    localparam int WC = 1;
    localparam int WP = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  internal_data_bus;
    logic [7:0]  read_data;
    logic [3:0]  write_address, write_count, write_page, read_address, read_count;
    logic        read_done, clear_byte_pointer, master_clear;
    logic [1:0]  channel_select;
    logic        initialize, next_word, address_hold, address_decrement;
    logic [3:0]  autoinit_enable;
    logic        page_carry_enable, clear_tc_status;
    logic [15:0] transfer_address;
    logic [7:0]  transfer_page;
    logic        update_high_address, terminal_count;
    logic [3:0]  tc_status;

    int n_checks = 0;
    int n_fail   = 0;
    logic u;

    kf8237_address_count_array dut (
        .clock(clock), .reset(reset), .internal_data_bus(internal_data_bus),
        .read_data(read_data), .write_address(write_address), .write_count(write_count),
        .write_page(write_page), .read_address(read_address), .read_count(read_count),
        .read_done(read_done), .clear_byte_pointer(clear_byte_pointer),
        .master_clear(master_clear), .channel_select(channel_select),
        .initialize(initialize), .next_word(next_word), .address_hold(address_hold),
        .address_decrement(address_decrement), .autoinit_enable(autoinit_enable),
        .page_carry_enable(page_carry_enable), .clear_tc_status(clear_tc_status),
        .transfer_address(transfer_address), .transfer_page(transfer_page),
        .update_high_address(update_high_address), .terminal_count(terminal_count),
        .tc_status(tc_status)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input int kind, input int ch, input logic [7:0] d);
        internal_data_bus = d;
        if (kind == WA) write_address[ch] = 1'b1;
        else if (kind == WC) write_count[ch] = 1'b1;
        else write_page[ch] = 1'b1;
        tick();
        write_address = '0;
        write_count   = '0;
        write_page    = '0;
    endtask

    task automatic clr_ptr();
        clear_byte_pointer = 1'b1;
        tick();
        clear_byte_pointer = 1'b0;
    endtask

    task automatic step(output logic uha);
        next_word = 1'b1;
        #1 uha = update_high_address;
        tick();
        next_word = 1'b0;
    endtask

    task automatic test_reset();
        read_address = 4'b0001;
        #1;
        n_checks++; if (transfer_address !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", transfer_address, 16'h0000); end
        n_checks++; if (transfer_page !== 8'h00) begin n_fail++; $display("FAIL reset_page: got %h expected %h", transfer_page, 8'h00); end
        n_checks++; if (terminal_count !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %b expected 0", terminal_count); end
        n_checks++; if (tc_status !== 4'b0000) begin n_fail++; $display("FAIL reset_tcstat: got %b expected 0000", tc_status); end
        n_checks++; if (read_data !== 8'h00) begin n_fail++; $display("FAIL reset_read: got %h expected 00", read_data); end
        read_address = '0;
    endtask

    task automatic test_byte_rw();
        clr_ptr();
        wr(WA, 2, 8'h34); wr(WA, 2, 8'h12); wr(WC, 2, 8'h02); wr(WC, 2, 8'h00);
        read_address = 4'b0100;
        #1;
        n_checks++; if (read_data !== 8'h34) begin n_fail++; $display("FAIL rd_lo: got %h expected 34", read_data); end
        read_done = 1'b1; tick(); read_done = 1'b0;
        n_checks++; if (read_data !== 8'h12) begin n_fail++; $display("FAIL rd_hi: got %h expected 12", read_data); end
        read_done = 1'b1; tick(); read_done = 1'b0;
        n_checks++; if (read_data !== 8'h34) begin n_fail++; $display("FAIL rd_wrap: got %h expected 34", read_data); end
        read_address = '0;
        #1;
        n_checks++; if (read_data !== 8'h00) begin n_fail++; $display("FAIL rd_none: got %h expected 00", read_data); end
        read_count = 4'b0100;
        #1;
        n_checks++; if (read_data !== 8'h02) begin n_fail++; $display("FAIL rd_count: got %h expected 02", read_data); end
        read_count = '0;
        channel_select = 2'd2;
        tick();
        n_checks++; if (transfer_address !== 16'h1234) begin n_fail++; $display("FAIL xfer_ch2: got %h expected 1234", transfer_address); end
    endtask

    task automatic test_step();
        clr_ptr();
        wr(WA, 1, 8'hFF); wr(WA, 1, 8'h00); wr(WC, 1, 8'h01); wr(WC, 1, 8'h00);
        channel_select = 2'd1;
        step(u);
        n_checks++; if (u !== 1'b1) begin n_fail++; $display("FAIL step1_uha: got %b expected 1", u); end
        n_checks++; if (terminal_count !== 1'b0) begin n_fail++; $display("FAIL step1_tc: got %b expected 0", terminal_count); end
        step(u);
        n_checks++; if (u !== 1'b0) begin n_fail++; $display("FAIL step2_uha: got %b expected 0", u); end
        n_checks++; if (terminal_count !== 1'b1) begin n_fail++; $display("FAIL step2_tc: got %b expected 1", terminal_count); end
        n_checks++; if (tc_status !== 4'b0010) begin n_fail++; $display("FAIL step2_tcstat: got %b expected 0010", tc_status); end
        n_checks++; if (transfer_address !== 16'h0100) begin n_fail++; $display("FAIL step2_addr: got %h expected 0100", transfer_address); end
        read_count = 4'b0010;
        #1;
        n_checks++; if (read_data !== 8'hFF) begin n_fail++; $display("FAIL step2_cnt: got %h expected ff", read_data); end
        read_count = '0;
        step(u);
        n_checks++; if (terminal_count !== 1'b0) begin n_fail++; $display("FAIL step3_tc: got %b expected 0", terminal_count); end
        tick();
        n_checks++; if (transfer_address !== 16'h0102) begin n_fail++; $display("FAIL step3_addr: got %h expected 0102", transfer_address); end
    endtask

    task automatic test_autoinit();
        clr_ptr();
        wr(WA, 0, 8'h00); wr(WA, 0, 8'h10); wr(WC, 0, 8'h00); wr(WC, 0, 8'h00); wr(WP, 0, 8'h05);
        autoinit_enable = 4'b0001;
        channel_select  = 2'd0;
        step(u);
        n_checks++; if (u !== 1'b0) begin n_fail++; $display("FAIL ai_uha: got %b expected 0", u); end
        n_checks++; if (terminal_count !== 1'b1) begin n_fail++; $display("FAIL ai_tc: got %b expected 1", terminal_count); end
        n_checks++; if (tc_status !== 4'b0011) begin n_fail++; $display("FAIL ai_tcstat: got %b expected 0011", tc_status); end
        tick();
        n_checks++; if (transfer_address !== 16'h1000) begin n_fail++; $display("FAIL ai_addr: got %h expected 1000", transfer_address); end
        n_checks++; if (transfer_page !== 8'h05) begin n_fail++; $display("FAIL ai_page: got %h expected 05", transfer_page); end
        read_count = 4'b0001;
        #1;
        n_checks++; if (read_data !== 8'h00) begin n_fail++; $display("FAIL ai_cnt: got %h expected 00", read_data); end
        read_count = '0;
        clear_tc_status = 1'b1;
        step(u);
        clear_tc_status = 1'b0;
        n_checks++; if (tc_status !== 4'b0001) begin n_fail++; $display("FAIL set_over_clear: got %b expected 0001", tc_status); end
        autoinit_enable = '0;
    endtask

    task automatic test_page_carry();
        clr_ptr();
        wr(WP, 3, 8'h07); wr(WA, 3, 8'hFF); wr(WA, 3, 8'hFF); wr(WC, 3, 8'h10); wr(WC, 3, 8'h00);
        channel_select    = 2'd3;
        page_carry_enable = 1'b1;
        step(u);
        n_checks++; if (u !== 1'b1) begin n_fail++; $display("FAIL inc_uha: got %b expected 1", u); end
        n_checks++; if (terminal_count !== 1'b0) begin n_fail++; $display("FAIL inc_tc: got %b expected 0", terminal_count); end
        tick();
        n_checks++; if (transfer_address !== 16'h0000) begin n_fail++; $display("FAIL inc_addr: got %h expected 0000", transfer_address); end
        n_checks++; if (transfer_page !== 8'h08) begin n_fail++; $display("FAIL inc_page: got %h expected 08", transfer_page); end
        wr(WP, 3, 8'h00);
        address_decrement = 1'b1;
        step(u);
        n_checks++; if (u !== 1'b1) begin n_fail++; $display("FAIL dec_uha: got %b expected 1", u); end
        tick();
        n_checks++; if (transfer_address !== 16'hFFFF) begin n_fail++; $display("FAIL dec_addr: got %h expected ffff", transfer_address); end
        n_checks++; if (transfer_page !== 8'hFF) begin n_fail++; $display("FAIL dec_page: got %h expected ff", transfer_page); end
        address_hold = 1'b1;
        step(u);
        n_checks++; if (u !== 1'b0) begin n_fail++; $display("FAIL hold_uha: got %b expected 0", u); end
        tick();
        n_checks++; if (transfer_address !== 16'hFFFF) begin n_fail++; $display("FAIL hold_addr: got %h expected ffff", transfer_address); end
        address_hold      = 1'b0;
        address_decrement = 1'b0;
        page_carry_enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        channel_select  = 2'd1;
        clear_tc_status = 1'b1; tick(); clear_tc_status = 1'b0;
        n_checks++; if (tc_status !== 4'b0000) begin n_fail++; $display("FAIL tc_clear: got %b expected 0000", tc_status); end
        clr_ptr();
        wr(WC, 1, 8'h00); wr(WC, 1, 8'h00);
        internal_data_bus = 8'h05;
        write_count[1] = 1'b1;
        next_word = 1'b1;
        #1;
        n_checks++; if (update_high_address !== 1'b0) begin n_fail++; $display("FAIL col_uha: got %b expected 0", update_high_address); end
        tick();
        write_count = '0;
        next_word = 1'b0;
        n_checks++; if (terminal_count !== 1'b0) begin n_fail++; $display("FAIL col_tc: got %b expected 0", terminal_count); end
        n_checks++; if (tc_status !== 4'b0000) begin n_fail++; $display("FAIL col_tcstat: got %b expected 0000", tc_status); end
        tick();
        n_checks++; if (transfer_address !== 16'h0102) begin n_fail++; $display("FAIL col_addr: got %h expected 0102", transfer_address); end
        clr_ptr();
        read_count = 4'b0010;
        #1;
        n_checks++; if (read_data !== 8'h05) begin n_fail++; $display("FAIL col_cnt: got %h expected 05", read_data); end
        read_count = '0;
        initialize = 1'b1; tick(); initialize = 1'b0;
        tick();
        n_checks++; if (transfer_address !== 16'h00FF) begin n_fail++; $display("FAIL init_addr: got %h expected 00ff", transfer_address); end
    endtask

    task automatic test_clear_mid();
        channel_select = 2'd0;
        step(u);
        channel_select = 2'd2;
        clr_ptr();
        wr(WA, 2, 8'hAA);
        master_clear = 1'b1; tick(); master_clear = 1'b0;
        n_checks++; if (tc_status !== 4'b0000) begin n_fail++; $display("FAIL mc_tcstat: got %b expected 0000", tc_status); end
        n_checks++; if (transfer_address !== 16'h0000) begin n_fail++; $display("FAIL mc_addr: got %h expected 0000", transfer_address); end
        read_address = 4'b0100;
        #1;
        n_checks++; if (read_data !== 8'h00) begin n_fail++; $display("FAIL mc_read: got %h expected 00", read_data); end
        read_address = '0;
        wr(WA, 2, 8'h77);
        tick();
        n_checks++; if (transfer_address !== 16'h0077) begin n_fail++; $display("FAIL mc_ptr: got %h expected 0077", transfer_address); end
        next_word = 1'b1;
        reset = 1'b0;
        tick();
        next_word = 1'b0;
        reset = 1'b1;
        n_checks++; if (terminal_count !== 1'b0) begin n_fail++; $display("FAIL rst_tc: got %b expected 0", terminal_count); end
        n_checks++; if (tc_status !== 4'b0000) begin n_fail++; $display("FAIL rst_tcstat: got %b expected 0000", tc_status); end
        tick();
        n_checks++; if (transfer_address !== 16'h0000) begin n_fail++; $display("FAIL rst_addr: got %h expected 0000", transfer_address); end
        n_checks++; if (transfer_page !== 8'h00) begin n_fail++; $display("FAIL rst_page: got %h expected 00", transfer_page); end
    endtask

    initial begin
        reset = 1'b0;
        internal_data_bus = '0;
        write_address = '0; write_count = '0; write_page = '0;
        read_address = '0; read_count = '0; read_done = 1'b0;
        clear_byte_pointer = 1'b0; master_clear = 1'b0; channel_select = '0;
        initialize = 1'b0; next_word = 1'b0; address_hold = 1'b0; address_decrement = 1'b0;
        autoinit_enable = '0; page_carry_enable = 1'b0; clear_tc_status = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        test_reset();
        test_byte_rw();
        test_step();
        test_autoinit();
        test_page_carry();
        test_back_to_back();
        test_clear_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
